mmio_button_port: RTL

//  Memory-mapped I/O responder on the core's data bus: decodes loads/stores
//  to a 16-byte window at BASE, drives the LED output latch and serves

---
 rtl/mmio_button_port_if.sv | 11 +
 rtl/mmio_button_port.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mmio_button_port_if.sv
// Data-bus view of the MMIO button port: core-side store/load strobes, address, data and window hit.
interface mmio_button_port_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;

    modport master (output we, output a, output wd, input rd, input sel);
    modport slave  (input we, input a, input wd, output rd, output sel);
endinterface

// File: rtl/mmio_button_port.sv
// MMIO responder: LED latch, synchronized/debounced inputs and sticky rise flags in a 16-byte window.
// Define MMIO_PORT_IRQ_EN to add the MASK register and the registered irq output.
module mmio_button_port #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [31:0] BASE       = 32'h800,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    mmio_button_port_if.slave  bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic [WIDTH-1:0]   out_port
`ifdef MMIO_PORT_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam int unsigned    CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] debPrev_q;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] w1cBits;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             capen_q, capen_d;
    logic             hit;
    logic             wrEn;
    logic [1:0]       offset;
    logic             unusedBusBits;

`ifdef MMIO_PORT_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;
`endif

    assign hit           = (bus.a[31:4] == BASE[31:4]);
    assign offset        = bus.a[3:2];
    assign wrEn          = bus.we & hit;
    assign bus.sel       = hit;
    assign out_port      = out_q;
    assign unusedBusBits = &{1'b0, bus.a[1:0], bus.wd};

    // A bit only follows its synchronized pin after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Register writes; a fresh rise beats a same-cycle write-1-to-clear.
    always_comb begin
        out_d   = out_q;
        capen_d = capen_q;
        w1cBits = '0;
        if (wrEn) begin
            case (offset)
                2'd0:    out_d   = bus.wd[WIDTH-1:0];
                2'd1:    w1cBits = bus.wd[WIDTH-1:0];
                2'd2:    capen_d = bus.wd[0];
                default: ;
            endcase
        end
        edge_d = (edge_q & ~w1cBits) | (capen_q ? (deb_q & ~debPrev_q) : '0);
    end

`ifdef MMIO_PORT_IRQ_EN
    always_comb begin
        mask_d = mask_q;
        if (wrEn && offset == 2'd3) begin
            mask_d = bus.wd[WIDTH-1:0];
        end
        irq_d = |(edge_d & mask_q);
    end

    assign irq = irq_q;
`endif

    always_comb begin
        bus.rd = '0;
        if (hit) begin
            case (offset)
                2'd0:    bus.rd[WIDTH-1:0] = deb_q;
                2'd1:    bus.rd[WIDTH-1:0] = edge_q;
                2'd2:    bus.rd[0]         = capen_q;
`ifdef MMIO_PORT_IRQ_EN
                default: bus.rd[WIDTH-1:0] = mask_q;
`else
                default: bus.rd            = '0;
`endif
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            edge_q    <= '0;
            out_q     <= '0;
            capen_q   <= 1'b1;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            edge_q    <= edge_d;
            out_q     <= out_d;
            capen_q   <= capen_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef MMIO_PORT_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end
`endif

endmodule
